// File: rtl/ddr3_write_sequencer_pkg.sv
// Shared command encodings, FSM states and default timing for the DDR3 write sequencer.
package ddr3_pkg;

  localparam int T_RCD_DEF  = 11;
  localparam int T_CCD_DEF  = 4;
  localparam int T_WRAP_DEF = 16;
  localparam int T_RP_DEF   = 11;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_ACT = 2'b01,
    CMD_WR  = 2'b10,
    CMD_PRE = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_WRITE, S_WAIT_CCD, S_WAIT_WRAP
  } state_e;

  typedef struct packed {
    logic [2:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
    logic [15:0] data;
    logic        close;
  } wr_req_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ddr3_write_sequencer_if.sv
// Host request / command-encoder bus of the write sequencer.
interface ddr3_write_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_bank;
  logic [14:0] req_row;
  logic [9:0]  req_col;
  logic [15:0] req_data;
  logic        req_close;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [2:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmd_ap;
  logic [15:0] cmd_data;
  logic        busy;

  modport slave (
    input  req_valid, req_bank, req_row, req_col, req_data, req_close,
    output req_ready, cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, cmd_ap, cmd_data, busy
  );

  modport master (
    output req_valid, req_bank, req_row, req_col, req_data, req_close,
    input  req_ready, cmd_valid, cmd, cmd_bank, cmd_row, cmd_col, cmd_ap, cmd_data, busy
  );
endinterface

// File: rtl/ddr3_write_sequencer_timer.sv
// Loadable down-counter that parks at zero; zero flag is combinational on the count.
module ddr3_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/ddr3_write_sequencer.sv
// Single-bank-at-a-time DDR3 write sequencer: open-row tracking, PRE/ACT/WR issue with
// exact tRP/tRCD/tCCD/write-recovery spacing from one shared down-counter.
module ddr3_write_sequencer
  import ddr3_pkg::*;
#(
  parameter int T_RCD  = T_RCD_DEF,
  parameter int T_CCD  = T_CCD_DEF,
  parameter int T_WRAP = T_WRAP_DEF,
  parameter int T_RP   = T_RP_DEF
) (
  input  logic                   clk,
  input  logic                   areset_n,
  ddr3_write_sequencer_if.slave  bus
);
  localparam int CW = $clog2(max4(T_RCD, T_CCD, T_WRAP, T_RP));

  state_e      state_q, state_d;
  wr_req_t     req_q, req_d;
  logic        open_valid_q, open_valid_d;
  logic [2:0]  open_bank_q, open_bank_d;
  logic [14:0] open_row_q, open_row_d;
  logic        tmr_load, tmr_zero;
  logic [CW-1:0] tmr_val;
  logic        accept, row_hit;

  // Wait states last T-1 cycles, so the counter is loaded with T-2 and exits on zero.
  ddr3_timer #(.W(CW)) u_timer (
    .clk(clk), .areset_n(areset_n), .load(tmr_load), .load_val(tmr_val), .zero(tmr_zero)
  );

  assign accept  = (state_q == S_IDLE) && bus.req_valid;
  assign row_hit = open_valid_q && (open_bank_q == bus.req_bank) && (open_row_q == bus.req_row);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (accept) state_d = row_hit ? S_WRITE : (open_valid_q ? S_PRE : S_ACT);
      S_PRE:       state_d = S_WAIT_RP;
      S_WAIT_RP:   if (tmr_zero) state_d = S_ACT;
      S_ACT:       state_d = S_WAIT_RCD;
      S_WAIT_RCD:  if (tmr_zero) state_d = S_WRITE;
      S_WRITE:     state_d = req_q.close ? S_WAIT_WRAP : S_WAIT_CCD;
      S_WAIT_CCD,
      S_WAIT_WRAP: if (tmr_zero) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    unique case (state_q)
      S_PRE:   begin bus.cmd_valid = 1'b1; bus.cmd = CMD_PRE; end
      S_ACT:   begin bus.cmd_valid = 1'b1; bus.cmd = CMD_ACT; end
      S_WRITE: begin bus.cmd_valid = 1'b1; bus.cmd = CMD_WR;  end
      default: ;
    endcase
  end

  always_comb begin
    req_d        = req_q;
    open_valid_d = open_valid_q;
    open_bank_d  = open_bank_q;
    open_row_d   = open_row_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    if (accept)
      req_d = '{bank: bus.req_bank, row: bus.req_row, col: bus.req_col,
                data: bus.req_data, close: bus.req_close};
    unique case (state_q)
      S_PRE: begin
        open_valid_d = 1'b0;
        tmr_load     = 1'b1;
        tmr_val      = CW'(T_RP - 2);
      end
      S_ACT: begin
        open_valid_d = 1'b1;
        open_bank_d  = req_q.bank;
        open_row_d   = req_q.row;
        tmr_load     = 1'b1;
        tmr_val      = CW'(T_RCD - 2);
      end
      S_WRITE: begin
        if (req_q.close) open_valid_d = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = req_q.close ? CW'(T_WRAP - 2) : CW'(T_CCD - 2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      req_q        <= '0;
      open_valid_q <= 1'b0;
      open_bank_q  <= '0;
      open_row_q   <= '0;
    end else begin
      req_q        <= req_d;
      open_valid_q <= open_valid_d;
      open_bank_q  <= open_bank_d;
      open_row_q   <= open_row_d;
    end
  end

  assign bus.cmd_bank = req_q.bank;
  assign bus.cmd_row  = req_q.row;
  assign bus.cmd_col  = req_q.col;
  assign bus.cmd_ap   = req_q.close;
  assign bus.cmd_data = req_q.data;
endmodule
